// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, round-constant start value, GF(2^8) xtime and the
// key-schedule / cipher-control state encoding.
package aes_pkg;

   localparam int NR    = 10;
   localparam int KEY_W = 128;
   localparam int RK_W  = 128;
   localparam int EXP_W = (NR + 1) * RK_W;

   localparam logic [7:0] RCON_INIT = 8'h01;

   typedef enum logic {
      IDLE,
      EXPAND
   } aes_state_e;

   // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: one byte in, its substitution out.
module aes_sbox (
   input  logic [7:0] value,
   output logic [7:0] subst
);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign subst = SBOX[value];

endmodule

// File: rtl/keyexpansion.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-slot expanded-key bus.
// Optional per-round key stream enabled by macro KEYEXPANSION_ROUNDKEY_PORT_EN.
//
// Handshake: start is accepted on any rising edge where busy==0 (state IDLE); key is sampled
// only on that edge. busy stays high for the 10 expansion edges; finish pulses one cycle
// after the last slot is written, and a start in that cycle is accepted immediately.
module keyexpansion
   import aes_pkg::*;
#(
   parameter int NR    = aes_pkg::NR,
   parameter int KEY_W = aes_pkg::KEY_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [KEY_W-1:0]          key,
   input  logic                      start,
   output logic [(NR+1)*KEY_W-1:0]   expanded_key,
   output logic                      busy,
   output logic                      finish
`ifdef KEYEXPANSION_ROUNDKEY_PORT_EN
   ,
   output logic [KEY_W-1:0]          round_key,
   output logic [3:0]                round_idx,
   output logic                      round_valid
`endif
);

   if (NR != 10 || KEY_W != 128) begin : g_bad_cfg
      $error("keyexpansion supports AES-128 only (NR=10, KEY_W=128)");
   end

   aes_state_e        state;
   aes_state_e        state_next;
   logic              busy_next;
   logic              finish_next;
   logic              load;
   logic              step;
   logic              last;
   logic [3:0]        rnd;
   logic [7:0]        rcon;
   logic [RK_W-1:0]   prev_key;
   logic [RK_W-1:0]   next_key;
   logic [31:0]       w0, w1, w2, w3;
   logic [31:0]       rot_w, sub_w, t_w;
   logic [31:0]       n0, n1, n2, n3;

   always_comb begin
      prev_key = '0;
      for (int r = 1; r <= NR; r++) begin
         if (rnd == 4'(r)) prev_key = expanded_key[(r-1)*RK_W +: RK_W];
      end
   end

   assign w0    = prev_key[127:96];
   assign w1    = prev_key[95:64];
   assign w2    = prev_key[63:32];
   assign w3    = prev_key[31:0];
   assign rot_w = {w3[23:0], w3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_subword
      aes_sbox u_sbox (
         .value (rot_w[8*i +: 8]),
         .subst (sub_w[8*i +: 8])
      );
   end

   assign t_w      = sub_w ^ {rcon, 24'h0};
   assign n0       = w0 ^ t_w;
   assign n1       = w1 ^ n0;
   assign n2       = w2 ^ n1;
   assign n3       = w3 ^ n2;
   assign next_key = {n0, n1, n2, n3};

   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = EXPAND;
            end
         end
         EXPAND: begin
            step = 1'b1;
            if (rnd == 4'(NR)) begin
               last       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      busy_next   = (state_next == EXPAND);
      finish_next = last;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         busy         <= 1'b0;
         finish       <= 1'b0;
         rnd          <= 4'd0;
         rcon         <= RCON_INIT;
         expanded_key <= '0;
      end else begin
         state  <= state_next;
         busy   <= busy_next;
         finish <= finish_next;
         if (load) begin
            expanded_key[RK_W-1:0] <= key;
            rcon                   <= RCON_INIT;
            rnd                    <= 4'd1;
         end else if (step) begin
            for (int r = 1; r <= NR; r++) begin
               if (rnd == 4'(r)) expanded_key[r*RK_W +: RK_W] <= next_key;
            end
            rcon <= xtime(rcon);
            // Park the counter at 0 after the final round so it never exceeds NR.
            rnd  <= last ? 4'd0 : rnd + 4'd1;
         end
      end
   end

`ifdef KEYEXPANSION_ROUNDKEY_PORT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         round_key   <= '0;
         round_idx   <= 4'd0;
         round_valid <= 1'b0;
      end else begin
         round_valid <= load | step;
         if (load) begin
            round_key <= key;
            round_idx <= 4'd0;
         end else if (step) begin
            round_key <= next_key;
            round_idx <= rnd;
         end
      end
   end
`endif

endmodule

// File: tb/tb_keyexpansion.sv
// Self-checking bench for keyexpansion: FIPS-197 directed vectors plus random keys checked
// by a scoreboard against a field-arithmetic key-schedule model.
module tb_keyexpansion;

   localparam int EW = 1408;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            start = 1'b0;
   logic [127:0]    key = '0;
   logic [EW-1:0]   expanded_key;
   logic            busy;
   logic            finish;
`ifdef KEYEXPANSION_ROUNDKEY_PORT_EN
   logic [127:0]    round_key;
   logic [3:0]      round_idx;
   logic            round_valid;
`endif

   keyexpansion dut (
      .clk          (clk),
      .rst          (rst),
      .key          (key),
      .start        (start),
      .expanded_key (expanded_key),
      .busy         (busy),
      .finish       (finish)
`ifdef KEYEXPANSION_ROUNDKEY_PORT_EN
      ,
      .round_key    (round_key),
      .round_idx    (round_idx),
      .round_valid  (round_valid)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [127:0] KEY_A1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] A1_SLOT1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] A1_SLOT10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] Z_SLOT1   = 128'h62636363626363636263636362636363;
   localparam logic [127:0] Z_SLOT10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   int            total = 0;
   int            bad = 0;
   logic [EW-1:0] exp_q[$];
   int            acc_cyc[$];
   int            fin_cyc[$];
   int            busy_left = 0;
   logic          fin_exp = 1'b0;
   int            fin_count = 0;
   int            cyc = 0;
   int            rk_idx = 0;
   logic [7:0]    sb[256];

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sb[x] = s;
      end
   endtask

   function automatic logic [EW-1:0] model_expand(input logic [127:0] k);
      logic [31:0]   w[44];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [EW-1:0] res;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      res = '0;
      for (int r = 0; r < 11; r++) res[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return res;
   endfunction

   // ---------------- comparison helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, expv);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s actual=%b required=%b", name, act, expv);
      end
   endtask

   task automatic check_int(input string name, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, expv);
      end
   endtask

   // ---------------- scoreboard push: acceptance model ----------------
   always @(posedge clk) begin
      cyc++;
      fin_exp = 1'b0;
      if (rst) begin
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) fin_exp = 1'b1;
         end else if (start) begin
            exp_q.push_back(model_expand(key));
            acc_cyc.push_back(cyc);
            busy_left = 10;
         end
      end
   end

   // ---------------- monitor: pop and compare ----------------
   always @(negedge clk) begin
      logic [EW-1:0]  e;
      logic [127:0]   rk_exp;
      if (rst) begin
         check_bit("busy", busy, busy_left != 0);
         check_bit("finish", finish, fin_exp);
`ifdef KEYEXPANSION_ROUNDKEY_PORT_EN
         if (round_valid) begin
            check_int("round_idx", int'(round_idx), rk_idx);
            if (exp_q.size() > 0) begin
               e = exp_q[0];
               rk_exp = e[rk_idx*128 +: 128];
               check($sformatf("round_key%0d", rk_idx), round_key, rk_exp);
            end
            rk_idx = (rk_idx == 10) ? 0 : rk_idx + 1;
         end
`endif
         if (finish) begin
            fin_count++;
            fin_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL finish_unexpected actual=pulse required=none at cycle %0d", cyc);
            end else begin
               e = exp_q.pop_front();
               for (int r = 0; r < 11; r++)
                  check($sformatf("slot%0d", r), expanded_key[r*128 +: 128], e[r*128 +: 128]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_pulse(input logic [127:0] k);
      @(negedge clk);
      key   = k;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_fin(input int target, input int max, input string name);
      int n = 0;
      while (fin_count < target && n < max) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_bit({name, "_timeout"}, fin_count >= target, 1'b1);
   endtask

   task automatic clear_model();
      exp_q.delete();
      busy_left = 0;
      fin_exp   = 1'b0;
      rk_idx    = 0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int f0;
      int d;
      build_sbox();

      #1;
      check_bit("reset_busy", busy, 1'b0);
      check_bit("reset_finish", finish, 1'b0);
      check_bit("reset_ek_zero", |expanded_key, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // FIPS-197 A.1 vector with latency check
      f0 = fin_count;
      start_pulse(KEY_A1);
      wait_fin(f0 + 1, 20, "a1");
      check_int("a1_latency", fin_cyc[$] - acc_cyc[$], 10);
      check("a1_slot0", expanded_key[127:0], KEY_A1);
      check("a1_slot1", expanded_key[255:128], A1_SLOT1);
      check("a1_slot10", expanded_key[1407:1280], A1_SLOT10);

      // zero key
      f0 = fin_count;
      start_pulse(128'h0);
      wait_fin(f0 + 1, 20, "zero");
      check("zero_slot0", expanded_key[127:0], 128'h0);
      check("zero_slot1", expanded_key[255:128], Z_SLOT1);
      check("zero_slot10", expanded_key[1407:1280], Z_SLOT10);

      // start pulses while busy are ignored
      f0 = fin_count;
      start_pulse(KEY_A1);
      repeat (2) @(negedge clk);
      key = {$urandom, $urandom, $urandom, $urandom};
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      key = {$urandom, $urandom, $urandom, $urandom};
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_fin(f0 + 1, 20, "ignore");
      repeat (5) @(negedge clk);
      check_int("ignore_one_finish", fin_count - f0, 1);
      check("ignore_slot10", expanded_key[1407:1280], A1_SLOT10);

      // reset in the middle of an expansion
      f0 = fin_count;
      start_pulse(KEY_A1);
      repeat (4) @(negedge clk);
      #2;
      rst = 1'b0;
      clear_model();
      #1;
      check_bit("midrst_busy", busy, 1'b0);
      check_bit("midrst_finish", finish, 1'b0);
      check_bit("midrst_ek_zero", |expanded_key, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (15) @(negedge clk);
      check_int("midrst_no_finish", fin_count - f0, 0);
      start_pulse(KEY_A1);
      wait_fin(f0 + 1, 20, "post_rst");
      check("post_rst_slot10", expanded_key[1407:1280], A1_SLOT10);

      // start held high across two expansions
      f0 = fin_count;
      @(negedge clk);
      key   = KEY_A1;
      start = 1'b1;
      @(posedge clk);
      #1;
      key = 128'h0;
      repeat (11) @(posedge clk);
      #1;
      start = 1'b0;
      wait_fin(f0 + 2, 30, "held");
      check_int("held_gap", fin_cyc[$] - fin_cyc[$-1], 11);
      check("held_slot1", expanded_key[255:128], Z_SLOT1);
      check("held_slot10", expanded_key[1407:1280], Z_SLOT10);

      // random keys with occasional ignored starts
      for (int it = 0; it < 20; it++) begin
         f0 = fin_count;
         start_pulse({$urandom, $urandom, $urandom, $urandom});
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom_range(1, 7);
            repeat (d) @(negedge clk);
            key = {$urandom, $urandom, $urandom, $urandom};
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         wait_fin(f0 + 1, 20, "rand");
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check_int("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
